// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
//   Shared types for the reorder buffer: depth and slot widths, the physical
//   register type, the rename payload arriving from rename and the retired-row
//   record handed back to rename's free pool.
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 64;  // entries, power of 2, >= 4
  localparam int DISPATCH_W = 2;   // dispatch slots per cycle
  localparam int COMPLETE_W = 3;   // writeback ports per cycle
  localparam int RETIRE_W   = 3;   // retire slots per cycle
  localparam int P_REG_W    = 7;   // physical register address width
  localparam int RET_CNT_W  = $clog2(RETIRE_W + 1);

  typedef logic [P_REG_W-1:0]           p_reg;
  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_idx_t;
  typedef logic [$clog2(ROB_DEPTH):0]   rob_cnt_t;

  typedef struct packed {
    logic RegWrite;
    p_reg PRegAddrDst;
    p_reg OldPRegAddrDst;
  } rename_struct;

  typedef struct packed {
    logic valid;
    p_reg PRegAddrDst;
    p_reg OldPRegAddrDst;
  } rob_row_struct;

endpackage

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
//   Groups the dispatch, writeback and retire signals of the reorder buffer.
//   master : rename / writeback side (drives i_*, observes o_*)
//   slave  : the reorder buffer itself
//   Signals:
//     i_dispatch_valid / i_rename_data   two renamed ops per cycle
//     o_dispatch_ready / o_rob_idx       acceptance and assigned entry indices
//     i_wb_valid / i_wb_rob_idx          completion reports, one per port
//     o_complete_rob_rows                retired rows (registered, one cycle)
//     o_count / o_empty / o_full         occupancy
// -----------------------------------------------------------------------------
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic [DISPATCH_W-1:0] i_dispatch_valid;
  rename_struct          i_rename_data [0:DISPATCH_W-1];
  logic                  o_dispatch_ready;
  rob_idx_t              o_rob_idx [0:DISPATCH_W-1];
  logic [COMPLETE_W-1:0] i_wb_valid;
  rob_idx_t              i_wb_rob_idx [0:COMPLETE_W-1];
  rob_row_struct         o_complete_rob_rows [0:RETIRE_W-1];
  rob_cnt_t              o_count;
  logic                  o_empty;
  logic                  o_full;

  modport master (
    output i_dispatch_valid, i_rename_data, i_wb_valid, i_wb_rob_idx,
    input  o_dispatch_ready, o_rob_idx, o_complete_rob_rows, o_count, o_empty, o_full
  );

  modport slave (
    input  i_dispatch_valid, i_rename_data, i_wb_valid, i_wb_rob_idx,
    output o_dispatch_ready, o_rob_idx, o_complete_rob_rows, o_count, o_empty, o_full
  );

endinterface

// File: rtl/rob_retire_select.sv
// -----------------------------------------------------------------------------
// rob_retire_select
//   Combinational retire-width selector. Looks at the RETIRE_W entries starting
//   at head (wrapping past DEPTH-1 to 0) and returns the length of the leading
//   run of entries that are both valid and done.
//   Ports:
//     head   oldest entry index
//     valid  per-entry valid flags
//     done   per-entry done flags
//     n_ret  number of entries to retire this cycle (0..RETIRE_W)
// -----------------------------------------------------------------------------
module rob_retire_select
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [IDX_W-1:0]     head,
  input  logic [DEPTH-1:0]     valid,
  input  logic [DEPTH-1:0]     done,
  output logic [RET_CNT_W-1:0] n_ret
);

  logic             run;
  logic [IDX_W-1:0] slot;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned (no latch), and blocking '=' is used here because each
    // iteration must see the value produced by the previous one.
    n_ret = '0;
    run   = 1'b1;
    slot  = head;
    for (int k = 0; k < RETIRE_W; k++) begin
      slot = head + IDX_W'(k);  // natural wrap, DEPTH is a power of 2
      if (run && valid[slot] && done[slot]) begin
        n_ret = n_ret + RET_CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   In-order retirement buffer downstream of rename. Accepts two renamed ops
//   per cycle, marks completion from three writeback ports and retires up to
//   three oldest done entries per cycle, emitting the retired rows so rename
//   can free OldPRegAddrDst.
//   Ports:
//     i_clk  clock, all state on posedge
//     i_rst  synchronous active-high reset
//     rob    reorder_buffer_if.slave (dispatch / writeback / retire / occupancy)
//   Optional: define ROB_TRACE_EN to print every retired row; cycle behaviour
//   is the same with or without it.
// -----------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH = reorder_buffer_pkg::ROB_DEPTH,
  localparam int IDX_W = $clog2(ROB_DEPTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  reorder_buffer_if.slave  rob
);

  logic [IDX_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q;
  logic [ROB_DEPTH-1:0] valid_q, done_q;
  p_reg                 dst_q [ROB_DEPTH];
  p_reg                 old_q [ROB_DEPTH];
  rob_row_struct        rows_q [RETIRE_W];

  logic                  ready;
  logic [DISPATCH_W-1:0] accept;
  logic [IDX_W-1:0]      disp_idx [DISPATCH_W];
  logic [1:0]            n_disp;
  logic [RET_CNT_W-1:0]  n_ret;
  logic [IDX_W-1:0]      ret_idx [RETIRE_W];

  // Ready looks at the pre-retire count, so a slot being freed this cycle is
  // never reused in the same cycle; all-or-nothing acceptance of the pair.
  assign ready       = (count_q <= CNT_W'(ROB_DEPTH - 2));
  assign accept      = rob.i_dispatch_valid & {DISPATCH_W{ready}};
  // Slots compact: a slot1-only dispatch lands on tail.
  assign disp_idx[0] = tail_q;
  assign disp_idx[1] = tail_q + IDX_W'(rob.i_dispatch_valid[0]);
  assign n_disp      = {1'b0, accept[0]} + {1'b0, accept[1]};

  always_comb begin
    for (int k = 0; k < RETIRE_W; k++) begin
      ret_idx[k] = head_q + IDX_W'(k);
    end
  end

  rob_retire_select #(.DEPTH(ROB_DEPTH)) u_retire_select (
    .head  (head_q),
    .valid (valid_q),
    .done  (done_q),
    .n_ret (n_ret)
  );

  // Control state. Order inside the block matters: writeback sets done first,
  // retire clears afterwards (last assignment wins), then dispatch initialises
  // fresh entries, which are always distinct from the retiring ones.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking '<=' only, so every read in
    // this block sees the value from the start of the cycle.
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      for (int k = 0; k < RETIRE_W; k++) begin
        rows_q[k] <= '0;
      end
    end else begin
      for (int p = 0; p < COMPLETE_W; p++) begin
        if (rob.i_wb_valid[p] && valid_q[rob.i_wb_rob_idx[p]]) begin
          done_q[rob.i_wb_rob_idx[p]] <= 1'b1;
        end
      end
      for (int k = 0; k < RETIRE_W; k++) begin
        if (k < int'(n_ret)) begin
          valid_q[ret_idx[k]] <= 1'b0;
          done_q[ret_idx[k]]  <= 1'b0;
          rows_q[k].valid          <= (dst_q[ret_idx[k]] != '0);
          rows_q[k].PRegAddrDst    <= dst_q[ret_idx[k]];
          rows_q[k].OldPRegAddrDst <= old_q[ret_idx[k]];
        end else begin
          rows_q[k] <= '0;
        end
      end
      for (int s = 0; s < DISPATCH_W; s++) begin
        if (accept[s]) begin
          valid_q[disp_idx[s]] <= 1'b1;
          done_q[disp_idx[s]]  <= 1'b0;
        end
      end
      head_q  <= head_q + IDX_W'(n_ret);
      tail_q  <= tail_q + IDX_W'(n_disp);
      count_q <= count_q + CNT_W'(n_disp) - CNT_W'(n_ret);
    end
  end

  // Payload storage.
  // NOTE: the register-address arrays are deliberately not reset; they are
  // only read for entries whose valid flag (which is reset) is set.
  always_ff @(posedge i_clk) begin
    for (int s = 0; s < DISPATCH_W; s++) begin
      if (accept[s]) begin
        // An op that does not write a register retires as dst 0 (silent).
        dst_q[disp_idx[s]] <= rob.i_rename_data[s].RegWrite ?
                              rob.i_rename_data[s].PRegAddrDst : '0;
        old_q[disp_idx[s]] <= rob.i_rename_data[s].OldPRegAddrDst;
      end
    end
  end

`ifdef ROB_TRACE_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int k = 0; k < RETIRE_W; k++) begin
        if (k < int'(n_ret)) begin
          $display("ROB retire idx=%0d dst=%0d old=%0d%s", ret_idx[k],
                   dst_q[ret_idx[k]], old_q[ret_idx[k]],
                   (dst_q[ret_idx[k]] == '0) ? " <<<NO DEST>>>" : "");
        end
      end
    end
  end
`endif

  assign rob.o_dispatch_ready = ready;
  assign rob.o_rob_idx[0]     = rob_idx_t'(disp_idx[0]);
  assign rob.o_rob_idx[1]     = rob_idx_t'(disp_idx[1]);
  assign rob.o_count          = rob_cnt_t'(count_q);
  assign rob.o_empty          = (count_q == '0);
  assign rob.o_full           = (count_q == CNT_W'(ROB_DEPTH));

  always_comb begin
    for (int k = 0; k < RETIRE_W; k++) begin
      rob.o_complete_rob_rows[k] = rows_q[k];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Self-checking bench for reorder_buffer. A queue of in-flight ops (oldest
//   first) is the reference: dispatch pushes, writeback marks done, and the
//   leading done ops (up to three) pop and become the expected retired rows.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int D = ROB_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if rob_if ();

  reorder_buffer dut (
    .i_clk (clk),
    .i_rst (rst),
    .rob   (rob_if.slave)
  );

  typedef struct {
    int idx;
    int dst;
    int old;
    bit done;
  } ent_t;

  ent_t q[$];
  int   head_m   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic rename_struct mk(input bit rw, input int d, input int o);
    rename_struct r;
    r.RegWrite       = rw;
    r.PRegAddrDst    = p_reg'(d);
    r.OldPRegAddrDst = p_reg'(o);
    return r;
  endfunction

  // One clock: drive at negedge, check combinational outputs, advance the
  // model, then check the registered outputs just after the posedge.
  task automatic cycle(input logic [1:0] dv, input rename_struct r0, input rename_struct r1,
                       input logic [2:0] wv, input int w0, input int w1, input int w2);
    int            tail, nret, slot;
    bit            rdy;
    int            wb[3];
    rename_struct  rs[2];
    rob_row_struct exp_rows[3];
    @(negedge clk);
    rob_if.i_dispatch_valid = dv;
    rob_if.i_rename_data[0] = r0;
    rob_if.i_rename_data[1] = r1;
    rob_if.i_wb_valid       = wv;
    rob_if.i_wb_rob_idx[0]  = rob_idx_t'(w0);
    rob_if.i_wb_rob_idx[1]  = rob_idx_t'(w1);
    rob_if.i_wb_rob_idx[2]  = rob_idx_t'(w2);
    #1;
    rdy  = (q.size() <= D - 2);
    tail = (head_m + q.size()) % D;
    check("ready", 32'(rob_if.o_dispatch_ready), 32'(rdy));
    check("rob_idx0", 32'(rob_if.o_rob_idx[0]), 32'(tail));
    check("rob_idx1", 32'(rob_if.o_rob_idx[1]), 32'((tail + int'(dv[0])) % D));
    // Retire width from state at cycle start.
    nret = 0;
    while (nret < 3 && nret < q.size() && q[nret].done) nret++;
    for (int k = 0; k < 3; k++) begin
      exp_rows[k] = '0;
      if (k < nret) begin
        exp_rows[k].valid          = (q[k].dst != 0);
        exp_rows[k].PRegAddrDst    = p_reg'(q[k].dst);
        exp_rows[k].OldPRegAddrDst = p_reg'(q[k].old);
      end
    end
    wb[0] = w0; wb[1] = w1; wb[2] = w2;
    for (int p = 0; p < 3; p++) begin
      if (wv[p]) begin
        for (int i = 0; i < q.size(); i++) if (q[i].idx == wb[p]) q[i].done = 1'b1;
      end
    end
    for (int k = 0; k < nret; k++) void'(q.pop_front());
    head_m = (head_m + nret) % D;
    if (rdy) begin
      rs[0] = r0; rs[1] = r1;
      slot = tail;
      for (int s = 0; s < 2; s++) begin
        if (dv[s]) begin
          q.push_back('{slot, rs[s].RegWrite ? int'(rs[s].PRegAddrDst) : 0,
                        int'(rs[s].OldPRegAddrDst), 1'b0});
          slot = (slot + 1) % D;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("row%0d", k), 32'(rob_if.o_complete_rob_rows[k]), 32'(exp_rows[k]));
    end
    check("count", 32'(rob_if.o_count), 32'(q.size()));
    check("empty", 32'(rob_if.o_empty), 32'(q.size() == 0));
    check("full", 32'(rob_if.o_full), 32'(q.size() == D));
  endtask

  task automatic idle();
    cycle(2'b00, '0, '0, 3'b000, 0, 0, 0);
  endtask

  task automatic dispatch(input logic [1:0] dv, input rename_struct r0, input rename_struct r1);
    cycle(dv, r0, r1, 3'b000, 0, 0, 0);
  endtask

  // Report up to three not-yet-done entries per cycle until the model is empty.
  task automatic drain();
    int budget = 0;
    while (q.size() > 0 && budget < 200) begin
      int          w[3];
      logic [2:0]  wv = '0;
      int          n  = 0;
      w = '{0, 0, 0};
      for (int i = 0; i < q.size() && n < 3; i++) begin
        if (!q[i].done) begin
          w[n] = q[i].idx; wv[n] = 1'b1; n++;
        end
      end
      cycle(2'b00, '0, '0, wv, w[0], w[1], w[2]);
      budget++;
    end
    check("drain_done", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rob_if.i_dispatch_valid = '0;
    rob_if.i_wb_valid       = '0;
    @(posedge clk);
    #1;
    q.delete();
    head_m = 0;
    check("rst_count", 32'(rob_if.o_count), 32'd0);
    check("rst_ready", 32'(rob_if.o_dispatch_ready), 32'd1);
    check("rst_empty", 32'(rob_if.o_empty), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_row%0d", k), 32'(rob_if.o_complete_rob_rows[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rob_if.i_dispatch_valid = '0;
    rob_if.i_rename_data[0] = '0;
    rob_if.i_rename_data[1] = '0;
    rob_if.i_wb_valid       = '0;
    for (int p = 0; p < 3; p++) rob_if.i_wb_rob_idx[p] = '0;

    // Reset, then a first pair lands on entries 0 and 1.
    do_reset();
    dispatch(2'b11, mk(1, 32, 5), mk(1, 33, 6));
    check("t1_count", 32'(rob_if.o_count), 32'd2);

    // Younger op completes first: nothing retires until the head completes.
    cycle(2'b00, '0, '0, 3'b001, 1, 0, 0);
    cycle(2'b00, '0, '0, 3'b001, 0, 0, 0);
    idle();
    check("t2_row0", 32'(rob_if.o_complete_rob_rows[0]), 32'({1'b1, 7'd32, 7'd5}));
    check("t2_row1", 32'(rob_if.o_complete_rob_rows[1]), 32'({1'b1, 7'd33, 7'd6}));
    check("t2_empty", 32'(rob_if.o_empty), 32'd1);

    // Fill to full; further dispatch is ignored.
    do_reset();
    for (int i = 0; i < 32; i++) dispatch(2'b11, mk(1, 2 * i + 1, i), mk(1, 2 * i + 2, i + 64));
    check("t3_full", 32'(rob_if.o_full), 32'd1);
    for (int i = 0; i < 3; i++) dispatch(2'b11, mk(1, 99, 98), mk(1, 97, 96));
    check("t3_count_hold", 32'(rob_if.o_count), 32'd64);
    drain();

    // Move head/tail to 62, then dispatch across the wrap point.
    for (int i = 0; i < 31; i++) dispatch(2'b11, mk(1, 10 + i, 20 + i), mk(1, 50 + i, 90 + i));
    drain();
    check("t4_head_pos", 32'(rob_if.o_rob_idx[0]), 32'd62);
    dispatch(2'b11, mk(1, 40, 1), mk(1, 41, 2));
    dispatch(2'b11, mk(1, 42, 3), mk(1, 43, 4));
    drain();

    // Advance tail to 7, then a slot1-only no-dest op.
    dispatch(2'b11, mk(1, 11, 12), mk(1, 13, 14));
    dispatch(2'b11, mk(1, 15, 16), mk(1, 17, 18));
    dispatch(2'b01, mk(1, 19, 20), '0);
    drain();
    check("t5_tail", 32'(rob_if.o_rob_idx[0]), 32'd7);
    dispatch(2'b10, '0, mk(0, 77, 9));
    drain();

    // Five done entries behind an incomplete head, then reset: nothing retires.
    dispatch(2'b11, mk(1, 21, 22), mk(1, 23, 24));
    dispatch(2'b11, mk(1, 25, 26), mk(1, 27, 28));
    dispatch(2'b11, mk(1, 29, 30), mk(1, 31, 32));
    cycle(2'b00, '0, '0, 3'b111, q[1].idx, q[2].idx, q[3].idx);
    cycle(2'b00, '0, '0, 3'b011, q[4].idx, q[5].idx, 0);
    idle();
    do_reset();
    for (int i = 0; i < 3; i++) idle();

    // Randomized traffic: a filling phase then a balanced phase.
    for (int c = 0; c < 2000; c++) begin
      logic [1:0] dv;
      logic [2:0] wv;
      int         w[3];
      int         wb_pct = (c < 600) ? 25 : 70;
      dv = 2'($urandom_range(0, 3));
      for (int p = 0; p < 3; p++) begin
        wv[p] = ($urandom_range(0, 99) < wb_pct);
        if (q.size() > 0 && $urandom_range(0, 9) < 8) w[p] = q[$urandom_range(0, q.size() - 1)].idx;
        else w[p] = $urandom_range(0, D - 1);
      end
      cycle(dv, mk($urandom_range(0, 7) != 0, $urandom_range(0, 127), $urandom_range(0, 127)),
            mk($urandom_range(0, 7) != 0, $urandom_range(0, 127), $urandom_range(0, 127)),
            wv, w[0], w[1], w[2]);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
